mdu_scheduler: RTL and testbench

//   Sequences the multi-cycle multiply/divide unit (MDU) and owns the HI/LO registers.

---
 rtl/mdu_scheduler_pkg.sv | 30 +++
 rtl/mdu_arith.sv | 79 +++++++
 rtl/mdu_scheduler.sv | 104 ++++++++++
 tb/tb_mdu_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_scheduler_pkg.sv
// Shared MDU op codes and small op-classification helpers for the multiply/divide unit.
package mdu_scheduler_pkg;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6,
      MDU_READ  = 3'd7
   } mdu_op_e;

   localparam int MDU_W = 32;

   function automatic logic is_mult(input mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

   function automatic logic is_div(input mdu_op_e op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   // Ops that occupy HI/LO for several cycles and therefore must stall stage D.
   function automatic logic is_multicycle(input mdu_op_e op);
      return is_mult(op) || is_div(op);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational MDU datapath: 64-bit products and quotient/remainder with the
// divide-by-zero and signed-overflow results fixed to architectural values.
module mdu_arith
   import mdu_scheduler_pkg::*;
(
   input  mdu_op_e            op_i,
   input  logic [MDU_W-1:0]   operand_a_i,
   input  logic [MDU_W-1:0]   operand_b_i,
   output logic [MDU_W-1:0]   res_hi_o,
   output logic [MDU_W-1:0]   res_lo_o
);

   logic signed [2*MDU_W-1:0] prod_s;
   logic        [2*MDU_W-1:0] prod_u;
   logic signed [MDU_W-1:0]   dividend_s;
   logic signed [MDU_W-1:0]   divisor_s;
   logic signed [MDU_W-1:0]   quot_s;
   logic signed [MDU_W-1:0]   rem_s;
   logic        [MDU_W-1:0]   divisor_u;
   logic        [MDU_W-1:0]   quot_u;
   logic        [MDU_W-1:0]   rem_u;
   logic                      div_zero;
   logic                      div_ovf;

   assign prod_s = $signed({{MDU_W{operand_a_i[MDU_W-1]}}, operand_a_i})
                 * $signed({{MDU_W{operand_b_i[MDU_W-1]}}, operand_b_i});
   assign prod_u = {{MDU_W{1'b0}}, operand_a_i} * {{MDU_W{1'b0}}, operand_b_i};

   assign div_zero = (operand_b_i == '0);
   assign div_ovf  = (operand_a_i == 32'h8000_0000) && (operand_b_i == 32'hFFFF_FFFF);

   // The divider never sees a zero or overflowing divisor; those cases are overridden below.
   assign dividend_s = $signed(operand_a_i);
   assign divisor_s  = (div_zero || div_ovf) ? 32'sd1 : $signed(operand_b_i);
   assign divisor_u  = div_zero ? 32'd1 : operand_b_i;

   assign quot_s = dividend_s / divisor_s;
   assign rem_s  = dividend_s % divisor_s;
   assign quot_u = operand_a_i / divisor_u;
   assign rem_u  = operand_a_i % divisor_u;

   always_comb begin
      res_hi_o = '0;
      res_lo_o = '0;
      case (op_i)
         MDU_MULT: begin
            res_hi_o = prod_s[2*MDU_W-1:MDU_W];
            res_lo_o = prod_s[MDU_W-1:0];
         end
         MDU_MULTU: begin
            res_hi_o = prod_u[2*MDU_W-1:MDU_W];
            res_lo_o = prod_u[MDU_W-1:0];
         end
         MDU_DIV: begin
            if (div_zero) begin
               res_hi_o = operand_a_i;
               res_lo_o = 32'hFFFF_FFFF;
            end else if (div_ovf) begin
               res_hi_o = '0;
               res_lo_o = 32'h8000_0000;
            end else begin
               res_hi_o = rem_s;
               res_lo_o = quot_s;
            end
         end
         MDU_DIVU: begin
            if (div_zero) begin
               res_hi_o = operand_a_i;
               res_lo_o = 32'hFFFF_FFFF;
            end else begin
               res_hi_o = rem_u;
               res_lo_o = quot_u;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_scheduler.sv
// MDU sequencer beside the stage-E ALU: owns HI/LO, counts out multi-cycle op latency
// and requests a stage-D stall while an MDU instruction there would see busy HI/LO.
module mdu_scheduler
   import mdu_scheduler_pkg::*;
#(
   parameter int MULT_LATENCY = 5,
   parameter int DIV_LATENCY  = 10
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [MDU_W-1:0]  operandA,
   input  logic [MDU_W-1:0]  operandB,
   input  logic              decodeUsesMdu,
   input  logic              readHi,
   output logic              busy,
   output logic              stallRequest,
   output logic [MDU_W-1:0]  hi,
   output logic [MDU_W-1:0]  lo,
   output logic [MDU_W-1:0]  readData
);

   localparam int MAX_LAT = (MULT_LATENCY > DIV_LATENCY) ? MULT_LATENCY : DIV_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   mdu_op_e            op_e;
   logic [MDU_W-1:0]   res_hi;
   logic [MDU_W-1:0]   res_lo;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [MDU_W-1:0]   pend_hi_q, pend_hi_d;
   logic [MDU_W-1:0]   pend_lo_q, pend_lo_d;
   logic [MDU_W-1:0]   hi_q, hi_d;
   logic [MDU_W-1:0]   lo_q, lo_d;
   logic               idle;

   assign op_e = mdu_op_e'(op);
   assign idle = (cnt_q == '0);

   mdu_arith u_arith (
      .op_i        (op_e),
      .operand_a_i (operandA),
      .operand_b_i (operandB),
      .res_hi_o    (res_hi),
      .res_lo_o    (res_lo)
   );

   // A start seen while counting (including the final count edge) is dropped: the
   // in-flight op owns HI/LO until it retires.
   always_comb begin
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      if (!idle) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end else if (start) begin
         case (op_e)
            MDU_MULT, MDU_MULTU: begin
               pend_hi_d = res_hi;
               pend_lo_d = res_lo;
               cnt_d     = CNT_W'(MULT_LATENCY);
            end
            MDU_DIV, MDU_DIVU: begin
               pend_hi_d = res_hi;
               pend_lo_d = res_lo;
               cnt_d     = CNT_W'(DIV_LATENCY);
            end
            MDU_MTHI: hi_d = operandA;
            MDU_MTLO: lo_d = operandA;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy         = !idle;
   assign stallRequest = decodeUsesMdu && (busy || (start && is_multicycle(op_e)));
   assign hi           = hi_q;
   assign lo           = lo_q;
   assign readData     = readHi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Directed bench for mdu_scheduler: a cycle-count model of HI/LO retirement checked every
// falling edge, plus hand-computed expectations for each scenario.
module tb_mdu_scheduler;
   import mdu_scheduler_pkg::*;

   localparam int ML = 5;
   localparam int DL = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] operandA = '0;
   logic [31:0] operandB = '0;
   logic        decodeUsesMdu = 1'b0;
   logic        readHi = 1'b0;
   logic        busy;
   logic        stallRequest;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] readData;

   int n_tests = 0;
   int n_fail  = 0;

   mdu_scheduler #(.MULT_LATENCY(ML), .DIV_LATENCY(DL)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .op            (op),
      .operandA      (operandA),
      .operandB      (operandB),
      .decodeUsesMdu (decodeUsesMdu),
      .readHi        (readHi),
      .busy          (busy),
      .stallRequest  (stallRequest),
      .hi            (hi),
      .lo            (lo),
      .readData      (readData)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: results retire a fixed number of edges after accept
   bit [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
   bit        m_pend = 1'b0;
   int        m_done = 0;
   int        cyc = 0;

   task automatic model_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               output bit [31:0] rh, output bit [31:0] rl);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, uq, ur, up;
      rh = '0;
      rl = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      if (o == MDU_MULT) begin
         q = sa * sb;
         rh = q[63:32];
         rl = q[31:0];
      end else if (o == MDU_MULTU) begin
         up = ua * ub;
         rh = up[63:32];
         rl = up[31:0];
      end else if (b == 32'd0) begin
         rh = a;
         rl = 32'hFFFF_FFFF;
      end else if (o == MDU_DIV) begin
         q = sa / sb;
         r = sa - q * sb;
         rh = r[31:0];
         rl = q[31:0];
      end else begin
         uq = ua / ub;
         ur = ua - uq * ub;
         rh = ur[31:0];
         rl = uq[31:0];
      end
   endtask

   always @(posedge clk or posedge reset) begin
      bit was_busy;
      if (reset) begin
         m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
         m_pend = 1'b0;
      end else begin
         cyc++;
         was_busy = m_pend;
         if (m_pend && cyc == m_done) begin
            m_hi = m_phi;
            m_lo = m_plo;
            m_pend = 1'b0;
         end
         if (start && !was_busy) begin
            if (op == MDU_MULT || op == MDU_MULTU || op == MDU_DIV || op == MDU_DIVU) begin
               model_result(op, operandA, operandB, m_phi, m_plo);
               m_pend = 1'b1;
               m_done = cyc + ((op == MDU_MULT || op == MDU_MULTU) ? ML : DL);
            end else if (op == MDU_MTHI) m_hi = operandA;
            else if (op == MDU_MTLO) m_lo = operandA;
         end
      end
   end

   // ---------------- compare process
   always @(negedge clk) begin
      bit mc;
      mc = (op == MDU_MULT || op == MDU_MULTU || op == MDU_DIV || op == MDU_DIVU);
      chk("model_busy", {31'b0, busy}, {31'b0, m_pend});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
      chk("model_read", readData, readHi ? m_hi : m_lo);
      chk("model_stall", {31'b0, stallRequest},
          {31'b0, decodeUsesMdu && (m_pend || (start && mc))});
   end

   // ---------------- driver tasks
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op = o;
      operandA = a;
      operandB = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      op = MDU_NONE;
   endtask

   // Called right after issue(): busy for lat intervals, then the result is visible.
   task automatic expect_result(input string name, input int lat,
                                input logic [31:0] eh, input logic [31:0] el);
      for (int i = 0; i < lat; i++) begin
         @(negedge clk);
         chk({name, "_busy"}, {31'b0, busy}, 32'd1);
      end
      @(negedge clk);
      chk({name, "_idle"}, {31'b0, busy}, 32'd0);
      chk({name, "_hi"}, hi, eh);
      chk({name, "_lo"}, lo, el);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_stall", {31'b0, stallRequest}, 32'd0);
      reset = 1'b0;
      idle(1);

      // 1. multu
      issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
      expect_result("multu", ML, 32'd1, 32'hFFFF_FFFE);
      readHi = 1'b1; #1;
      chk("read_hi", readData, 32'd1);
      readHi = 1'b0; #1;
      chk("read_lo", readData, 32'hFFFF_FFFE);
      idle(1);

      // 2. mult signed
      issue(MDU_MULT, -32'sd3, 32'd7);
      expect_result("mult", ML, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

      // 3. divides, including zero divisor and signed overflow
      issue(MDU_DIV, -32'sd7, 32'd2);
      expect_result("div", DL, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      issue(MDU_DIVU, 32'd7, 32'd0);
      expect_result("divu0", DL, 32'd7, 32'hFFFF_FFFF);
      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      expect_result("divovf", DL, 32'd0, 32'h8000_0000);
      issue(MDU_DIVU, 32'd100, 32'd7);
      expect_result("divu", DL, 32'd2, 32'd14);

      // 4. stall window of a divide, then mthi while idle
      decodeUsesMdu = 1'b1;
      start = 1'b1; op = MDU_DIV; operandA = 32'd20; operandB = 32'd3;
      @(negedge clk);
      chk("stall_accept", {31'b0, stallRequest}, 32'd1);
      @(posedge clk); #1;
      start = 1'b0; op = MDU_NONE;
      for (int i = 0; i < DL; i++) begin
         @(negedge clk);
         chk("stall_busy", {31'b0, stallRequest}, 32'd1);
      end
      @(negedge clk);
      chk("stall_release", {31'b0, stallRequest}, 32'd0);
      chk("stall_lo", lo, 32'd6);
      chk("stall_hi", hi, 32'd2);
      @(posedge clk); #1;
      start = 1'b1; op = MDU_MTHI; operandA = 32'd5;
      @(negedge clk);
      chk("mthi_nostall", {31'b0, stallRequest}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0; op = MDU_NONE;
      @(negedge clk);
      chk("mthi_hi", hi, 32'd5);
      chk("mthi_busy", {31'b0, busy}, 32'd0);
      decodeUsesMdu = 1'b0;
      @(posedge clk); #1;
      issue(MDU_MTLO, 32'h1234_5678, 32'd0);
      @(negedge clk);
      chk("mtlo_lo", lo, 32'h1234_5678);
      chk("mtlo_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;

      // 5. async reset mid-op discards the result
      issue(MDU_MULT, 32'd3, 32'd4);
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle(8);
      chk("arst_after_hi", hi, 32'd0);
      chk("arst_after_lo", lo, 32'd0);
      chk("arst_after_busy", {31'b0, busy}, 32'd0);

      // 6. start while busy is ignored, also on the final count edge
      issue(MDU_MULT, 32'd3, 32'd4);
      issue(MDU_MULT, 32'd100, 32'd100);
      expect_result("ignore", ML - 1, 32'd0, 32'd12);
      issue(MDU_MULT, 32'd6, 32'd7);
      idle(ML - 1);
      issue(MDU_MULT, 32'd9, 32'd9);
      @(negedge clk);
      chk("last_edge_busy", {31'b0, busy}, 32'd0);
      chk("last_edge_lo", lo, 32'd42);
      chk("last_edge_hi", hi, 32'd0);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
